// File: rtl/rtio_output_scheduler_if.sv
// Read-side port of the timestamped event FIFO (first-word-fall-through).
// The scheduler owns the pop strobe; the FIFO supplies the head entry and empty flag.
interface rtio_output_scheduler_if #(
    parameter int DATA_WIDTH = 68
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/rtio_output_scheduler.sv
// Timestamped output scheduler: pops events from a FWFT FIFO and fires each one
// the cycle after the free-running time counter reaches its timestamp.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no event pending; head of FIFO may be latched
//   ST_WAIT | event held in ts_q/pl_q, fires once counter >= ts_q
module rtio_output_scheduler #(
    parameter int DATA_WIDTH = 68,
    parameter int TS_WIDTH   = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    rtio_output_scheduler_if.master          fifo,
    input  logic                             counter_load,
    input  logic [TS_WIDTH-1:0]              counter_value,
    input  logic                             underflow_clr,
    output logic [TS_WIDTH-1:0]              counter,
    output logic                             out_valid,
    output logic [DATA_WIDTH-TS_WIDTH-1:0]   out_data,
    output logic                             underflow,
    output logic [TS_WIDTH-1:0]              underflow_ts,
    output logic                             busy
);

    localparam int PW = DATA_WIDTH - TS_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   counter_q, counter_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [PW-1:0]         pl_q, pl_d;
    logic                  out_valid_q, out_valid_d;
    logic [PW-1:0]         out_data_q, out_data_d;
    logic                  underflow_q, underflow_d;
    logic [TS_WIDTH-1:0]   underflow_ts_q, underflow_ts_d;

    logic [TS_WIDTH-1:0]   head_ts;
    logic [PW-1:0]         head_pl;
    logic                  fire;
    logic                  latch;
    logic                  late;

    assign head_ts = fifo.fifo_dout[DATA_WIDTH-1:PW];
    assign head_pl = fifo.fifo_dout[PW-1:0];

    // Fire does not depend on enable so a counter_load past the timestamp still fires.
    assign fire  = (state_q == ST_WAIT) && (counter_q >= ts_q);
    assign latch = rst_n && enable && !fifo.fifo_empty
                   && ((state_q == ST_IDLE) || fire);
    assign late  = head_ts < counter_q;

    assign fifo.fifo_rd_en = latch;

    always_comb begin
        counter_d = counter_q;
        if (counter_load) begin
            counter_d = counter_value;
        end else if (enable) begin
            counter_d = counter_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d        = state_q;
        ts_d           = ts_q;
        pl_d           = pl_q;
        out_valid_d    = 1'b0;
        out_data_d     = out_data_q;
        underflow_d    = underflow_q;
        underflow_ts_d = underflow_ts_q;

        if (underflow_clr) begin
            underflow_d = 1'b0;
        end

        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = pl_q;
            state_d     = ST_IDLE;
        end

        // A latch in the same cycle as fire overrides the return to idle,
        // and a fresh underflow wins over a simultaneous clear.
        if (latch) begin
            if (late) begin
                underflow_d    = 1'b1;
                underflow_ts_d = head_ts;
                state_d        = ST_IDLE;
            end else begin
                ts_d    = head_ts;
                pl_d    = head_pl;
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            ts_q           <= '0;
            pl_q           <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            underflow_q    <= 1'b0;
            underflow_ts_q <= '0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            ts_q           <= ts_d;
            pl_q           <= pl_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            underflow_q    <= underflow_d;
            underflow_ts_q <= underflow_ts_d;
        end
    end

    assign counter      = counter_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign underflow    = underflow_q;
    assign underflow_ts = underflow_ts_q;
    assign busy         = (state_q == ST_WAIT);

endmodule

// File: tb/tb_rtio_output_scheduler.sv
// Directed bench for rtio_output_scheduler: a small FWFT FIFO model feeds
// hand-timed events and every output is compared against hand-computed values.
module tb_rtio_output_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        counter_load;
    logic [63:0] counter_value;
    logic        underflow_clr;
    logic [63:0] counter;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        underflow;
    logic [63:0] underflow_ts;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int pop_cnt = 0;

    logic [67:0] fifo_mem [16];
    logic [7:0]  rd_ptr = '0;
    logic [7:0]  wr_ptr = '0;

    rtio_output_scheduler_if #(.DATA_WIDTH(68)) fifo_bus ();

    assign fifo_bus.fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_bus.fifo_dout  = fifo_mem[rd_ptr[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_bus.fifo_rd_en) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    rtio_output_scheduler #(
        .DATA_WIDTH(68),
        .TS_WIDTH  (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo         (fifo_bus),
        .counter_load (counter_load),
        .counter_value(counter_value),
        .underflow_clr(underflow_clr),
        .counter      (counter),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .underflow    (underflow),
        .underflow_ts (underflow_ts),
        .busy         (busy)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] ts, input logic [3:0] pl);
        fifo_mem[wr_ptr[3:0]] = {ts, pl};
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < max_cyc) begin
            tick();
            n++;
        end
        chk_eq({tag, "_seen"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        logic [63:0] max_ts;
        logic [63:0] vcnt [3];
        logic [3:0]  vdat [3];
        int          nv;
        int          p0;

        max_ts        = '1;
        rst_n         = 1'b0;
        enable        = 1'b1;
        counter_load  = 1'b0;
        counter_value = '0;
        underflow_clr = 1'b0;

        // reset with an entry already waiting in the FIFO
        push(64'd10, 4'h5);
        tick();
        chk_eq("rst_rd_en",   64'(fifo_bus.fifo_rd_en), 64'd0);
        chk_eq("rst_counter", counter, 64'd0);
        chk_eq("rst_busy",    64'(busy), 64'd0);
        chk_eq("rst_valid",   64'(out_valid), 64'd0);
        chk_eq("rst_data",    64'(out_data), 64'd0);
        chk_eq("rst_uf",      64'(underflow), 64'd0);
        chk_eq("rst_uf_ts",   underflow_ts, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_eq("basic_rd_en", 64'(fifo_bus.fifo_rd_en), 64'd1);
        tick();
        chk_eq("basic_busy",  64'(busy), 64'd1);
        chk_eq("basic_pop",   64'(pop_cnt), 64'd1);
        chk_eq("basic_cnt1",  counter, 64'd1);
        wait_valid(30, "basic");
        chk_eq("basic_fire_cnt", counter, 64'd11);
        chk_eq("basic_data",     64'(out_data), 64'h5);
        tick();
        chk_eq("basic_strobe", 64'(out_valid), 64'd0);
        chk_eq("basic_idle",   64'(busy), 64'd0);
        chk_eq("basic_hold",   64'(out_data), 64'h5);

        // late event after a counter load
        counter_load  = 1'b1;
        counter_value = 64'd100;
        tick();
        counter_load = 1'b0;
        chk_eq("load_cnt", counter, 64'd100);
        push(64'd50, 4'h7);
        #1;
        chk_eq("late_rd_en", 64'(fifo_bus.fifo_rd_en), 64'd1);
        tick();
        chk_eq("late_uf",    64'(underflow), 64'd1);
        chk_eq("late_uf_ts", underflow_ts, 64'd50);
        chk_eq("late_busy",  64'(busy), 64'd0);
        chk_eq("late_pop",   64'(pop_cnt), 64'd2);
        nv = 0;
        repeat (3) begin
            tick();
            nv += int'(out_valid);
        end
        chk_eq("late_no_valid", 64'(nv), 64'd0);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk_eq("uf_clr", 64'(underflow), 64'd0);
        push(64'd60, 4'h0);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk_eq("uf_set_wins", 64'(underflow), 64'd1);
        chk_eq("uf_set_ts",   underflow_ts, 64'd60);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk_eq("uf_clr2", 64'(underflow), 64'd0);

        // back-to-back events, equal timestamps
        counter_load  = 1'b1;
        counter_value = 64'd15;
        tick();
        counter_load = 1'b0;
        push(64'd20, 4'h1);
        push(64'd20, 4'h2);
        push(64'd21, 4'h3);
        nv = 0;
        repeat (20) begin
            tick();
            if (out_valid && nv < 3) begin
                vcnt[nv] = counter;
                vdat[nv] = out_data;
                nv++;
            end
        end
        chk_eq("b2b_count", 64'(nv), 64'd3);
        chk_eq("b2b_cnt0",  vcnt[0], 64'd21);
        chk_eq("b2b_dat0",  64'(vdat[0]), 64'h1);
        chk_eq("b2b_cnt1",  vcnt[1], 64'd22);
        chk_eq("b2b_dat1",  64'(vdat[1]), 64'h2);
        chk_eq("b2b_cnt2",  vcnt[2], 64'd23);
        chk_eq("b2b_dat2",  64'(vdat[2]), 64'h3);
        chk_eq("b2b_uf",    64'(underflow), 64'd0);
        chk_eq("b2b_idle",  64'(busy), 64'd0);

        // pause with an event pending
        counter_load  = 1'b1;
        counter_value = 64'd25;
        tick();
        counter_load = 1'b0;
        push(64'd40, 4'h9);
        tick();
        chk_eq("pause_busy0", 64'(busy), 64'd1);
        repeat (4) tick();
        chk_eq("pause_cnt30", counter, 64'd30);
        enable = 1'b0;
        push(64'd41, 4'hA);
        p0 = pop_cnt;
        nv = 0;
        repeat (20) begin
            tick();
            nv += int'(out_valid);
        end
        chk_eq("pause_frozen", counter, 64'd30);
        chk_eq("pause_no_pop", 64'(pop_cnt), 64'(p0));
        chk_eq("pause_no_fire", 64'(nv), 64'd0);
        chk_eq("pause_busy",   64'(busy), 64'd1);
        enable = 1'b1;
        wait_valid(30, "resume");
        chk_eq("resume_cnt",  counter, 64'd41);
        chk_eq("resume_data", 64'(out_data), 64'h9);
        tick();
        chk_eq("resume2_valid", 64'(out_valid), 64'd1);
        chk_eq("resume2_cnt",   counter, 64'd42);
        chk_eq("resume2_data",  64'(out_data), 64'hA);
        tick();
        chk_eq("resume_idle", 64'(busy), 64'd0);

        // counter jumped past a pending timestamp while disabled
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        push(64'd1000, 4'h3);
        tick();
        chk_eq("jump_cnt5", counter, 64'd5);
        chk_eq("jump_busy", 64'(busy), 64'd1);
        enable        = 1'b0;
        counter_load  = 1'b1;
        counter_value = 64'd2000;
        tick();
        counter_load = 1'b0;
        chk_eq("jump_cnt",    counter, 64'd2000);
        chk_eq("jump_early",  64'(out_valid), 64'd0);
        tick();
        chk_eq("jump_valid",  64'(out_valid), 64'd1);
        chk_eq("jump_data",   64'(out_data), 64'h3);
        chk_eq("jump_hold",   counter, 64'd2000);
        enable = 1'b1;

        // counter wrap, then reset while waiting
        counter_load  = 1'b1;
        counter_value = max_ts - 64'd2;
        tick();
        counter_load = 1'b0;
        chk_eq("wrap_load", counter, max_ts - 64'd2);
        repeat (3) tick();
        chk_eq("wrap_zero", counter, 64'd0);
        push(64'd0, 4'hC);
        tick();
        chk_eq("wrap_busy", 64'(busy), 64'd1);
        tick();
        chk_eq("wrap_valid", 64'(out_valid), 64'd1);
        chk_eq("wrap_data",  64'(out_data), 64'hC);
        chk_eq("wrap_uf",    64'(underflow), 64'd0);
        push(64'd1, 4'h0);
        tick();
        chk_eq("wrap_late_uf", 64'(underflow), 64'd1);
        chk_eq("wrap_late_ts", underflow_ts, 64'd1);
        push(64'd50, 4'h5);
        tick();
        chk_eq("midwait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        nv = 0;
        repeat (3) begin
            tick();
            nv += int'(out_valid);
        end
        chk_eq("midrst_no_valid", 64'(nv), 64'd0);
        chk_eq("midrst_counter",  counter, 64'd0);
        chk_eq("midrst_busy",     64'(busy), 64'd0);
        chk_eq("midrst_data",     64'(out_data), 64'd0);
        chk_eq("midrst_uf",       64'(underflow), 64'd0);
        chk_eq("midrst_uf_ts",    underflow_ts, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
